// File: rtl/mitll_dfft_pkg.sv
// Shared constants and helpers for the mitll_dfft_pipe pulse pipeline.
package mitll_dfft_pkg;

    localparam int unsigned CNT_W     = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;

    localparam int unsigned WIDTH_MIN = 1;
    localparam int unsigned WIDTH_MAX = 32;
    localparam int unsigned DEPTH_MIN = 1;
    localparam int unsigned DEPTH_MAX = 8;

    // Number of set bits in a channel vector (zero-extended to WIDTH_MAX).
    function automatic logic [5:0] popcnt(input logic [WIDTH_MAX-1:0] v);
        logic [5:0] c;
        c = '0;
        for (int i = 0; i < int'(WIDTH_MAX); i++) begin
            c = c + {5'd0, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/mitll_dfft_cell.sv
// One channel of the pulse pipeline: a DEPTH-stage destructive-readout chain
// with a sticky flag for pulses that escape a full input stage.
// Optional macro MITLL_DFFT_PIPE_COMPL_EN adds the complementary output out_n.
module mitll_dfft_cell
    import mitll_dfft_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    input  logic rd,
    output logic out,
`ifdef MITLL_DFFT_PIPE_COMPL_EN
    output logic out_n,
`endif
    output logic err_dbl,
    output logic tail
);

    if (DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX) begin : gen_bad_depth
        $error("mitll_dfft_cell: DEPTH out of range");
    end

    logic [DEPTH-1:0] s_q, s_d;
    logic             out_q, out_d;
    logic             err_q, err_d;
    logic             out_n_q, out_n_d;

    // Next state: rd reads out the last stage and shifts, capturing in behind it.
    always_comb begin
        s_d     = s_q;
        err_d   = err_q;
        out_d   = 1'b0;
        out_n_d = 1'b0;
        if (rd) begin
            out_d   = s_q[DEPTH-1];
            out_n_d = ~s_q[DEPTH-1];
            s_d[0]  = in;
            for (int k = 1; k < int'(DEPTH); k++) begin
                s_d[k] = s_q[k-1];
            end
        end else if (in) begin
            // A second pulse into an occupied stage is lost.
            if (s_q[0]) begin
                err_d = 1'b1;
            end
            s_d[0] = 1'b1;
        end
    end

    // State registers with synchronous reset dominating all inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_q     <= '0;
            out_q   <= 1'b0;
            out_n_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            s_q     <= s_d;
            out_q   <= out_d;
            out_n_q <= out_n_d;
            err_q   <= err_d;
        end
    end

    assign out     = out_q;
    assign err_dbl = err_q;
    assign tail    = s_q[DEPTH-1];
`ifdef MITLL_DFFT_PIPE_COMPL_EN
    assign out_n   = out_n_q;
`else
    logic unused_out_n;
    assign unused_out_n = out_n_q;
`endif

endmodule

// File: rtl/mitll_dfft_pipe.sv
// WIDTH parallel DFF pulse pipelines sharing one readout strobe, with a
// saturating count of all emitted output pulses.
// Optional macro MITLL_DFFT_PIPE_COMPL_EN adds output out_n.
module mitll_dfft_pipe
    import mitll_dfft_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    input  logic             rd,
    output logic [WIDTH-1:0] out,
`ifdef MITLL_DFFT_PIPE_COMPL_EN
    output logic [WIDTH-1:0] out_n,
`endif
    output logic [WIDTH-1:0] err_dbl,
    output logic [CNT_W-1:0] pulse_cnt
);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : gen_bad_width
        $error("mitll_dfft_pipe: WIDTH out of range");
    end

    logic [WIDTH-1:0] tail;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W:0]   sum;

    for (genvar i = 0; i < int'(WIDTH); i++) begin : gen_cell
        mitll_dfft_cell #(
            .DEPTH(DEPTH)
        ) u_cell (
            .clk    (clk),
            .rst    (rst),
            .in     (in[i]),
            .rd     (rd),
            .out    (out[i]),
`ifdef MITLL_DFFT_PIPE_COMPL_EN
            .out_n  (out_n[i]),
`endif
            .err_dbl(err_dbl[i]),
            .tail   (tail[i])
        );
    end

    // Add the pulses about to be emitted, clamping at the counter maximum.
    always_comb begin
        sum   = {1'b0, cnt_q} + (CNT_W+1)'(popcnt(WIDTH_MAX'(tail)));
        cnt_d = sum[CNT_W] ? CNT_MAX : sum[CNT_W-1:0];
    end

    // Pulse counter advances only on readout edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (rd) begin
            cnt_q <= cnt_d;
        end
    end

    assign pulse_cnt = cnt_q;

endmodule

// File: tb/tb_mitll_dfft_pipe.sv
// Directed self-checking bench for mitll_dfft_pipe (WIDTH=4, DEPTH=2).
// Define MITLL_DFFT_PIPE_COMPL_EN to also check out_n.
module tb_mitll_dfft_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  in  = 4'b0000;
    logic        rd  = 1'b0;
    logic [3:0]  out;
    logic [3:0]  err_dbl;
    logic [15:0] pulse_cnt;
`ifdef MITLL_DFFT_PIPE_COMPL_EN
    logic [3:0]  out_n;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    mitll_dfft_pipe #(
        .WIDTH(4),
        .DEPTH(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in       (in),
        .rd       (rd),
        .out      (out),
`ifdef MITLL_DFFT_PIPE_COMPL_EN
        .out_n    (out_n),
`endif
        .err_dbl  (err_dbl),
        .pulse_cnt(pulse_cnt)
    );

    always #5 clk = ~clk;

    // Apply inputs for one edge, then settle past it before sampling.
    task automatic step(input logic [3:0] i, input logic r, input logic rs);
        in  = i;
        rd  = r;
        rst = rs;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step(4'b0000, 1'b0, 1'b1);
        step(4'b0000, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        step(4'b1111, 1'b1, 1'b1);
        step(4'b1111, 1'b1, 1'b1);
        n_cmp++;
        if (out !== 4'b0000) begin
            n_bad++; $display("FAIL reset_out: got %b want 0000", out);
        end
        n_cmp++;
        if (err_dbl !== 4'b0000) begin
            n_bad++; $display("FAIL reset_err: got %b want 0000", err_dbl);
        end
        n_cmp++;
        if (pulse_cnt !== 16'd0) begin
            n_bad++; $display("FAIL reset_cnt: got %0d want 0", pulse_cnt);
        end
        step(4'b0000, 1'b0, 1'b0);
    endtask

    task automatic test_latency();
        do_reset();
        step(4'b0001, 1'b0, 1'b0);
        step(4'b0000, 1'b1, 1'b0);
        n_cmp++;
        if (out !== 4'b0000) begin
            n_bad++; $display("FAIL lat_rd1: got %b want 0000", out);
        end
        step(4'b0000, 1'b1, 1'b0);
        n_cmp++;
        if (out !== 4'b0001) begin
            n_bad++; $display("FAIL lat_rd2: got %b want 0001", out);
        end
        n_cmp++;
        if (pulse_cnt !== 16'd1) begin
            n_bad++; $display("FAIL lat_cnt: got %0d want 1", pulse_cnt);
        end
        step(4'b0000, 1'b0, 1'b0);
        n_cmp++;
        if (out !== 4'b0000) begin
            n_bad++; $display("FAIL lat_idle: got %b want 0000", out);
        end
    endtask

    task automatic test_double();
        do_reset();
        step(4'b0010, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        step(4'b0010, 1'b0, 1'b0);
        n_cmp++;
        if (err_dbl !== 4'b0010) begin
            n_bad++; $display("FAIL dbl_err: got %b want 0010", err_dbl);
        end
        step(4'b0000, 1'b1, 1'b0);
        step(4'b0000, 1'b1, 1'b0);
        n_cmp++;
        if (out !== 4'b0010) begin
            n_bad++; $display("FAIL dbl_out: got %b want 0010", out);
        end
        step(4'b0000, 1'b1, 1'b0);
        n_cmp++;
        if (out !== 4'b0000) begin
            n_bad++; $display("FAIL dbl_single: got %b want 0000", out);
        end
        n_cmp++;
        if (pulse_cnt !== 16'd1) begin
            n_bad++; $display("FAIL dbl_cnt: got %0d want 1", pulse_cnt);
        end
        n_cmp++;
        if (err_dbl !== 4'b0010) begin
            n_bad++; $display("FAIL dbl_sticky: got %b want 0010", err_dbl);
        end
    endtask

    task automatic test_same_cycle();
        do_reset();
        step(4'b1000, 1'b0, 1'b0);
        // Occupied stage 0 plus rd: readout first, no escape.
        step(4'b1000, 1'b1, 1'b0);
        n_cmp++;
        if (err_dbl !== 4'b0000) begin
            n_bad++; $display("FAIL same_err: got %b want 0000", err_dbl);
        end
        step(4'b0000, 1'b1, 1'b0);
        n_cmp++;
        if (out !== 4'b1000) begin
            n_bad++; $display("FAIL same_out1: got %b want 1000", out);
        end
        step(4'b0000, 1'b1, 1'b0);
        n_cmp++;
        if (out !== 4'b1000) begin
            n_bad++; $display("FAIL same_out2: got %b want 1000", out);
        end
        n_cmp++;
        if (pulse_cnt !== 16'd2) begin
            n_bad++; $display("FAIL same_cnt: got %0d want 2", pulse_cnt);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        step(4'b1111, 1'b0, 1'b0);
        step(4'b1111, 1'b1, 1'b0);
        step(4'b1111, 1'b1, 1'b1);
        n_cmp++;
        if (out !== 4'b0000) begin
            n_bad++; $display("FAIL mid_out: got %b want 0000", out);
        end
        n_cmp++;
        if (pulse_cnt !== 16'd0) begin
            n_bad++; $display("FAIL mid_cnt: got %0d want 0", pulse_cnt);
        end
        n_cmp++;
        if (err_dbl !== 4'b0000) begin
            n_bad++; $display("FAIL mid_err: got %b want 0000", err_dbl);
        end
        step(4'b0000, 1'b1, 1'b0);
        step(4'b0000, 1'b1, 1'b0);
        n_cmp++;
        if (out !== 4'b0000 || pulse_cnt !== 16'd0) begin
            n_bad++;
            $display("FAIL mid_flush: got out=%b cnt=%0d want 0000/0", out, pulse_cnt);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        step(4'b0101, 1'b1, 1'b0);
        step(4'b1010, 1'b1, 1'b0);
        step(4'b0000, 1'b1, 1'b0);
        n_cmp++;
        if (out !== 4'b0101) begin
            n_bad++; $display("FAIL b2b_out1: got %b want 0101", out);
        end
`ifdef MITLL_DFFT_PIPE_COMPL_EN
        n_cmp++;
        if (out_n !== 4'b1010) begin
            n_bad++; $display("FAIL b2b_outn: got %b want 1010", out_n);
        end
`endif
        step(4'b0000, 1'b1, 1'b0);
        n_cmp++;
        if (out !== 4'b1010) begin
            n_bad++; $display("FAIL b2b_out2: got %b want 1010", out);
        end
        n_cmp++;
        if (pulse_cnt !== 16'd4) begin
            n_bad++; $display("FAIL b2b_cnt: got %0d want 4", pulse_cnt);
        end
        step(4'b0000, 1'b0, 1'b0);
        n_cmp++;
        if (out !== 4'b0000) begin
            n_bad++; $display("FAIL b2b_idle: got %b want 0000", out);
        end
`ifdef MITLL_DFFT_PIPE_COMPL_EN
        n_cmp++;
        if (out_n !== 4'b0000) begin
            n_bad++; $display("FAIL b2b_outn_idle: got %b want 0000", out_n);
        end
`endif
    endtask

    task automatic test_saturate();
        do_reset();
        step(4'b0011, 1'b0, 1'b0);
        step(4'b0000, 1'b1, 1'b0);
        step(4'b0000, 1'b1, 1'b0);
        // 16385 strobes with full input: first two fill, rest emit 4 each.
        for (int n = 0; n < 16385; n++) begin
            step(4'b1111, 1'b1, 1'b0);
        end
        n_cmp++;
        if (pulse_cnt !== 16'hFFFE) begin
            n_bad++; $display("FAIL sat_pre: got %h want fffe", pulse_cnt);
        end
        step(4'b0000, 1'b1, 1'b0);
        n_cmp++;
        if (out !== 4'b1111 || pulse_cnt !== 16'hFFFF) begin
            n_bad++;
            $display("FAIL sat_hit: got out=%b cnt=%h want 1111/ffff", out, pulse_cnt);
        end
        step(4'b0000, 1'b1, 1'b0);
        n_cmp++;
        if (out !== 4'b1111 || pulse_cnt !== 16'hFFFF) begin
            n_bad++;
            $display("FAIL sat_hold: got out=%b cnt=%h want 1111/ffff", out, pulse_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_double();
        test_same_cycle();
        test_reset_mid();
        test_back_to_back();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
